// File: rtl/freq_param_scheduler_if.sv
// Request/converter bundle for freq_param_scheduler.
// master = requesting side plus converter model, slave = scheduler.
interface freq_param_scheduler_if #(
   parameter int NCH = 4
);
   logic [NCH-1:0]    req;
   logic [NCH*10-1:0] adc_ch;
   logic [9:0]        conv_adc_out;
   logic [14:0]       conv_freq_in;
   logic [NCH*15-1:0] freq_ch;
   logic [NCH-1:0]    done;
   logic              skipped;
   logic              busy;

   modport master (
      output req,
      output adc_ch,
      output conv_freq_in,
      input  conv_adc_out,
      input  freq_ch,
      input  done,
      input  skipped,
      input  busy
   );

   modport slave (
      input  req,
      input  adc_ch,
      input  conv_freq_in,
      output conv_adc_out,
      output freq_ch,
      output done,
      output skipped,
      output busy
   );
endinterface

// File: rtl/freq_param_scheduler.sv
// Round-robin scheduler sharing one freqconvert between NCH channels.
// Dead-band skip suppresses conversions for pots that barely moved.
module freq_param_scheduler #(
   parameter int NCH          = 4,
   parameter int CONV_LATENCY = 1,
   parameter int HYST         = 2,
   parameter int FREQ_RST     = 20
) (
   input  logic                 clk,
   input  logic                 reset_n,
   freq_param_scheduler_if.slave bus
);

   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int CW = (CONV_LATENCY > 1) ? $clog2(CONV_LATENCY) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT
   } state_t;

   state_t            r_state;
   logic [NCH-1:0]    r_pend;
   logic [NCH-1:0]    r_done;
   logic              r_skip;
   logic              r_busy;
   logic [IW-1:0]     r_rr;
   logic [IW-1:0]     r_gch;
   logic [9:0]        r_code;
   logic [9:0]        r_conv;
   logic [CW-1:0]     r_cnt;
   logic [NCH-1:0]    r_have;
   logic [9:0]        r_last [NCH];
   logic [14:0]       r_freq [NCH];

   logic [9:0]        w_adc [NCH];
   logic [IW-1:0]     w_cand;
   logic [IW-1:0]     w_gnt;
   logic              w_hit;
   logic [9:0]        w_code;
   logic [9:0]        w_last;
   logic [10:0]       w_diff;
   logic              w_skip;
   logic              w_grant;
   logic [NCH-1:0]    w_clr;
   logic [NCH*15-1:0] w_fbus;

   // Split the packed ADC bus into per-channel codes.
   always_comb begin
      for (int k = 0; k < NCH; k++) begin
         w_adc[k] = bus.adc_ch[k*10 +: 10];
      end
   end

   // Round-robin search starting after the last granted channel;
   // scanning far-to-near lets the nearest pending channel win.
   always_comb begin
      w_hit  = 1'b0;
      w_gnt  = '0;
      w_cand = '0;
      for (int i = NCH; i >= 1; i--) begin
         w_cand = IW'((int'(r_rr) + i) % NCH);
         if (r_pend[w_cand]) begin
            w_hit = 1'b1;
            w_gnt = w_cand;
         end
      end
   end

   // Dead-band test on the candidate grant, 11-bit unsigned difference.
   always_comb begin
      w_code  = w_adc[w_gnt];
      w_last  = r_last[w_gnt];
      if (w_code >= w_last) begin
         w_diff = {1'b0, w_code} - {1'b0, w_last};
      end else begin
         w_diff = {1'b0, w_last} - {1'b0, w_code};
      end
      w_skip  = r_have[w_gnt] && (w_diff < 11'(HYST));
      w_grant = (r_state == S_IDLE) && w_hit;
      w_clr   = w_grant ? (NCH'(1) << w_gnt) : '0;
   end

   // Pack the frequency registers onto the output bus.
   always_comb begin
      w_fbus = '0;
      for (int k = 0; k < NCH; k++) begin
         w_fbus[k*15 +: 15] = r_freq[k];
      end
   end

   // Scheduler FSM: arbitrate, issue to the converter, wait, capture.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_pend  <= '0;
         r_done  <= '0;
         r_skip  <= 1'b0;
         r_busy  <= 1'b0;
         r_rr    <= '0;
         r_gch   <= '0;
         r_code  <= '0;
         r_conv  <= '0;
         r_cnt   <= '0;
         r_have  <= '0;
         for (int k = 0; k < NCH; k++) begin
            r_last[k] <= '0;
            r_freq[k] <= 15'(FREQ_RST);
         end
      end else begin
         r_done <= '0;
         r_skip <= 1'b0;
         // a request on the grant edge re-arms the channel
         r_pend <= (r_pend & ~w_clr) | bus.req;
         unique case (r_state)
            S_IDLE: begin
               if (w_hit) begin
                  r_rr   <= w_gnt;
                  r_gch  <= w_gnt;
                  r_code <= w_code;
                  if (w_skip) begin
                     r_done[w_gnt] <= 1'b1;
                     r_skip        <= 1'b1;
                  end else begin
                     r_busy  <= 1'b1;
                     r_state <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               r_conv  <= r_code;
               r_cnt   <= CW'(CONV_LATENCY - 1);
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (r_cnt == '0) begin
                  r_freq[r_gch] <= bus.conv_freq_in;
                  r_last[r_gch] <= r_code;
                  r_have[r_gch] <= 1'b1;
                  r_done[r_gch] <= 1'b1;
                  r_busy        <= 1'b0;
                  r_state       <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.conv_adc_out = r_conv;
   assign bus.freq_ch      = w_fbus;
   assign bus.done         = r_done;
   assign bus.skipped      = r_skip;
   assign bus.busy         = r_busy;

endmodule
